// File: rtl/updown_ctr_pkg.sv
// Shared types and constants for the parametrised up/down counter.
package updown_ctr_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : updown_ctr_pkg

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter; clock and reset stay outside.
interface param_updown_counter_if #(
  parameter int WIDTH = 8
);
  import updown_ctr_pkg::*;

  logic             en;
  logic             up_down;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  count_mode_e      mode;
  logic [WIDTH-1:0] q;
  logic             at_max;
  logic             at_min;
  logic             wrap_pulse;
  logic             sticky_wrap;

  modport master (
    output en, up_down, clr, load, load_val, mode,
    input  q, at_max, at_min, wrap_pulse, sticky_wrap
  );

  modport slave (
    input  en, up_down, clr, load, load_val, mode,
    output q, at_max, at_min, wrap_pulse, sticky_wrap
  );

endinterface : param_updown_counter_if

// File: rtl/updown_next_calc.sv
// Combinational next-count and wrap-event decode; priority clr > load > count > hold.
module updown_next_calc
  import updown_ctr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_V = '1
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             en_i,
  input  logic             up_down_i,
  input  count_mode_e      mode_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             wrap_evt_o
);

  always_comb begin
    q_next_o   = q_i;
    wrap_evt_o = 1'b0;
    if (clr_i) begin
      q_next_o = '0;
    end else if (load_i) begin
      q_next_o = (load_val_i > MAX_V) ? MAX_V : load_val_i;
    end else if (en_i) begin
      if (up_down_i == DIR_UP) begin
        // >= rather than == keeps q inside the range even for a non-power-of-two modulus
        if (q_i < MAX_V) begin
          q_next_o = q_i + WIDTH'(1);
        end else if (mode_i == MODE_WRAP) begin
          q_next_o   = '0;
          wrap_evt_o = 1'b1;
        end else begin
          q_next_o = MAX_V;
        end
      end else begin
        if (q_i != '0) begin
          q_next_o = q_i - WIDTH'(1);
        end else if (mode_i == MODE_WRAP) begin
          q_next_o   = MAX_V;
          wrap_evt_o = 1'b1;
        end
      end
    end
  end

endmodule : updown_next_calc

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap/saturate mode, load, clear and wrap flags.
module param_updown_counter
  import updown_ctr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 2**WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  param_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_evt;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             sticky_q, sticky_d;

  updown_next_calc #(
    .WIDTH (WIDTH),
    .MAX_V (MAX_V)
  ) u_next (
    .q_i        (q_q),
    .en_i       (bus.en),
    .up_down_i  (bus.up_down),
    .mode_i     (bus.mode),
    .clr_i      (bus.clr),
    .load_i     (bus.load),
    .load_val_i (bus.load_val),
    .q_next_o   (q_d),
    .wrap_evt_o (wrap_evt)
  );

  assign wrap_pulse_d = wrap_evt;
  assign sticky_d     = bus.clr ? 1'b0 : (sticky_q | wrap_evt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q          <= RST_V;
      wrap_pulse_q <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      q_q          <= q_d;
      wrap_pulse_q <= wrap_pulse_d;
      sticky_q     <= sticky_d;
    end
  end

  assign bus.q           = q_q;
  assign bus.at_max      = (q_q == MAX_V);
  assign bus.at_min      = (q_q == '0);
  assign bus.wrap_pulse  = wrap_pulse_q;
  assign bus.sticky_wrap = sticky_q;

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Directed and random checks of two counter configurations against an arithmetic model.
module tb_param_updown_counter;
  import updown_ctr_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   m1q, m2q;
  bit   m1wp, m1st, m2wp, m2st;
  int   wraps2;

  param_updown_counter_if #(.WIDTH(3)) bus1 ();
  param_updown_counter_if #(.WIDTH(8)) bus2 ();

  param_updown_counter #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  param_updown_counter #(.WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_next(input int m, input int q, input bit clr, input bit load,
                                   input bit en, input bit up, input bit sat, input int lv,
                                   output int nq, output bit wrap);
    int t;
    nq   = q;
    wrap = 1'b0;
    if (clr) nq = 0;
    else if (load) nq = (lv < m) ? lv : m - 1;
    else if (en) begin
      t = q + (up ? 1 : -1);
      if (t < 0 || t >= m) begin
        if (!sat) begin
          nq   = ((t % m) + m) % m;
          wrap = 1'b1;
        end
      end else nq = t;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("q1", 32'(bus1.q), 32'(m1q));
    check("at_max1", 32'(bus1.at_max), 32'(m1q == 5));
    check("at_min1", 32'(bus1.at_min), 32'(m1q == 0));
    check("wrap_pulse1", 32'(bus1.wrap_pulse), 32'(m1wp));
    check("sticky1", 32'(bus1.sticky_wrap), 32'(m1st));
    check("q2", 32'(bus2.q), 32'(m2q));
    check("wrap_pulse2", 32'(bus2.wrap_pulse), 32'(m2wp));
    check("sticky2", 32'(bus2.sticky_wrap), 32'(m2st));
  endtask

  task automatic model_reset();
    m1q = 0; m1wp = 0; m1st = 0;
    m2q = 0; m2wp = 0; m2st = 0;
  endtask

  // one clock edge: advance both models on the inputs that were just sampled
  task automatic step();
    int  nq;
    bit  w;
    ref_next(6, m1q, bus1.clr, bus1.load, bus1.en, bus1.up_down, bus1.mode == MODE_SAT,
             int'(bus1.load_val), nq, w);
    m1q = nq; m1wp = w; m1st = bus1.clr ? 1'b0 : (m1st | w);
    ref_next(256, m2q, bus2.clr, bus2.load, bus2.en, bus2.up_down, bus2.mode == MODE_SAT,
             int'(bus2.load_val), nq, w);
    m2q = nq; m2wp = w; m2st = bus2.clr ? 1'b0 : (m2st | w);
    @(posedge clk);
    #1;
    if (bus2.wrap_pulse === 1'b1) wraps2++;
    check_all();
  endtask

  initial begin
    n_assert = 0; n_fail = 0; wraps2 = 0;
    reset = 1'b0;
    bus1.en = 1'b1; bus1.up_down = DIR_UP; bus1.clr = 1'b0; bus1.load = 1'b0;
    bus1.load_val = '0; bus1.mode = MODE_WRAP;
    bus2.en = 1'b0; bus2.up_down = DIR_UP; bus2.clr = 1'b0; bus2.load = 1'b0;
    bus2.load_val = '0; bus2.mode = MODE_WRAP;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;

    // free-run up through the modulus-6 wrap
    for (int i = 0; i < 6; i++) begin
      step();
      check("up_seq", 32'(bus1.q), 32'((i + 1) % 6));
    end
    check("wrap_at_0", 32'(bus1.wrap_pulse), 32'd1);
    step();
    check("sticky_holds", 32'(bus1.sticky_wrap), 32'd1);

    // load 3 then count down through the 0 -> 5 wrap
    bus1.load = 1'b1; bus1.load_val = 3'd3;
    step();
    check("load3", 32'(bus1.q), 32'd3);
    bus1.load = 1'b0; bus1.up_down = DIR_DOWN;
    for (int i = 0; i < 5; i++) step();
    check("down_wrap_q", 32'(bus1.q), 32'd4);

    // saturate at the top, then step down
    bus1.mode = MODE_SAT; bus1.load = 1'b1; bus1.load_val = 3'd5;
    step();
    bus1.load = 1'b0; bus1.up_down = DIR_UP;
    for (int i = 0; i < 3; i++) step();
    check("sat_top", 32'(bus1.q), 32'd5);
    check("sat_no_pulse", 32'(bus1.wrap_pulse), 32'd0);
    bus1.up_down = DIR_DOWN;
    step(); step();
    check("sat_down", 32'(bus1.q), 32'd3);

    // out-of-range load clamps; clr beats load and clears sticky
    bus1.load = 1'b1; bus1.load_val = 3'd7;
    step();
    check("clamp", 32'(bus1.q), 32'd5);
    bus1.clr = 1'b1; bus1.load_val = 3'd2;
    step();
    check("clr_over_load", 32'(bus1.q), 32'd0);
    check("clr_sticky", 32'(bus1.sticky_wrap), 32'd0);
    bus1.clr = 1'b0;
    step();
    bus1.load = 1'b0; bus1.en = 1'b0; bus1.mode = MODE_WRAP;
    for (int i = 0; i < 4; i++) step();
    check("hold2", 32'(bus1.q), 32'd2);

    // asynchronous reset between edges
    bus1.en = 1'b1; bus1.up_down = DIR_UP;
    step();
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_q", 32'(bus1.q), 32'd0);
    check_all();
    #2 reset = 1'b1;

    // random traffic on the modulus-6 counter
    for (int i = 0; i < 300; i++) begin
      bus1.en       = ($urandom_range(0, 3) != 0);
      bus1.up_down  = 1'($urandom_range(0, 1));
      bus1.mode     = count_mode_e'($urandom_range(0, 1));
      bus1.clr      = ($urandom_range(0, 19) == 0);
      bus1.load     = ($urandom_range(0, 9) == 0);
      bus1.load_val = 3'($urandom_range(0, 7));
      step();
    end

    // 8-bit default configuration free-runs through one 255 -> 0 wrap
    bus1.clr = 1'b0; bus1.load = 1'b0; bus1.en = 1'b0;
    bus2.en = 1'b1;
    wraps2 = 0;
    for (int i = 0; i < 300; i++) step();
    check("wide_q_end", 32'(bus2.q), 32'd44);
    check("wide_one_wrap", 32'(wraps2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_param_updown_counter
